// File: rtl/ntt_sched.sv
// Address/twiddle scheduler for the 256-point Kyber NTT/INTT: one butterfly beat per handshake over 7 layers,
// with a 256-beat scaling pass in INTT mode. All outputs are registered and hold while the beat is not accepted.
module ntt_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       bf_ready,
    output logic       bf_valid,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [7:0] tw_addr,
    output logic [2:0] layer,
    output logic       scale,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCALE, S_DONE} state_t;

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic [2:0] l_q, l_d;
    logic [6:0] b_q, b_d, g_q, g_d, o_q, o_d;
    logic [7:0] sc_q, sc_d;

    logic       valid_q, valid_d, scale_q, scale_d, busy_q, busy_d, done_q, done_d;
    logic [7:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, tw_q, tw_d;
    logic [2:0] layer_q, layer_d;

    logic       accept;
    logic [3:0] lenlog_q, lenlog_d;
    logic [6:0] len_m1;
    logic [7:0] len_d, pa, pb, pt;
    logic [15:0] span;

    // log2 of the butterfly span: shrinks per layer for NTT, grows for INTT
    function automatic logic [3:0] lenlog_f(input logic m, input logic [2:0] l);
        return m ? ({1'b0, l} + 4'd1) : (4'd7 - {1'b0, l});
    endfunction

    assign accept   = valid_q & bf_ready;
    assign lenlog_q = lenlog_f(mode_q, l_q);
    assign len_m1   = 7'((8'd1 << lenlog_q) - 8'd1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        l_d     = l_q;
        b_d     = b_q;
        g_d     = g_q;
        o_d     = o_q;
        sc_d    = sc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    l_d     = 3'd0;
                    b_d     = 7'd0;
                    g_d     = 7'd0;
                    o_d     = 7'd0;
                    sc_d    = 8'd0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    b_d = b_q + 7'd1;
                    if (o_q == len_m1) begin
                        o_d = 7'd0;
                        if (b_q == 7'd127) begin
                            g_d = 7'd0;
                            if (l_q == 3'd6) state_d = mode_q ? S_SCALE : S_DONE;
                            else             l_d = l_q + 3'd1;
                        end else begin
                            g_d = g_q + 7'd1;
                        end
                    end else begin
                        o_d = o_q + 7'd1;
                    end
                end
            end
            S_SCALE: begin
                if (accept) begin
                    if (sc_q == 8'd255) state_d = S_DONE;
                    else                sc_d = sc_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // payload of the beat addressed by the next-state counters
    always_comb begin
        lenlog_d = lenlog_f(mode_d, l_d);
        len_d    = 8'd1 << lenlog_d;
        span     = 16'(g_d) << (lenlog_d + 4'd1);
        pa       = span[7:0] + {1'b0, o_d};
        pb       = pa + len_d;
        pt       = mode_d ? ((8'd128 >> l_d) - 8'd1 - {1'b0, g_d})
                          : ((8'd1 << l_d) + {1'b0, g_d});
    end

    always_comb begin
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        scale_d  = 1'b0;
        addr_a_d = 8'd0;
        addr_b_d = 8'd0;
        tw_d     = 8'd0;
        layer_d  = 3'd0;
        unique case (state_d)
            S_RUN: begin
                valid_d  = 1'b1;
                busy_d   = 1'b1;
                addr_a_d = pa;
                addr_b_d = pb;
                tw_d     = pt;
                layer_d  = l_d;
            end
            S_SCALE: begin
                valid_d  = 1'b1;
                busy_d   = 1'b1;
                scale_d  = 1'b1;
                addr_a_d = sc_d;
                addr_b_d = sc_d;
                layer_d  = 3'd6;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            l_q      <= 3'd0;
            b_q      <= 7'd0;
            g_q      <= 7'd0;
            o_q      <= 7'd0;
            sc_q     <= 8'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            scale_q  <= 1'b0;
            addr_a_q <= 8'd0;
            addr_b_q <= 8'd0;
            tw_q     <= 8'd0;
            layer_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            l_q      <= l_d;
            b_q      <= b_d;
            g_q      <= g_d;
            o_q      <= o_d;
            sc_q     <= sc_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            scale_q  <= scale_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            layer_q  <= layer_d;
        end
    end

    assign bf_valid = valid_q;
    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign tw_addr  = tw_q;
    assign layer    = layer_q;
    assign scale    = scale_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: golden beats are queued at start and popped on every accepted handshake.
module tb_ntt_sched;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, bf_ready = 1'b0;
    logic       bf_valid, scale, busy, done;
    logic [7:0] addr_a, addr_b, tw_addr;
    logic [2:0] layer;

    ntt_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bf_ready(bf_ready),
        .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
        .layer(layer), .scale(scale), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [27:0] beat_t;
    beat_t q[$];
    beat_t got[1152];
    int    n_total = 0, n_bad = 0;
    int    cyc, beats, done_n, done_at;
    bit    rnd = 1'b0, noise = 1'b0;

    function automatic beat_t mk(input int a, input int b, input int t, input int l, input bit s);
        return {8'(a), 8'(b), 8'(t), 3'(l), s};
    endfunction

    function automatic beat_t cur();
        return {addr_a, addr_b, tw_addr, layer, scale};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_golden(input bit m);
        for (int b = 0; b < 896; b++) begin
            int l, bb, len, g, o, a, t;
            l   = b / 128;
            bb  = b % 128;
            len = m ? (2 << l) : (128 >> l);
            g   = bb / len;
            o   = bb % len;
            a   = 2 * len * g + o;
            t   = m ? ((128 >> l) - 1 - g) : ((1 << l) + g);
            q.push_back(mk(a, a + len, t, l, 1'b0));
        end
        if (m) for (int i = 0; i < 256; i++) q.push_back(mk(i, i, 0, 6, 1'b1));
    endtask

    // one clock: drive, score the beat presented this cycle, advance, check hold
    task automatic tick();
        beat_t snap;
        bit    held;
        if (noise && cyc > 0) begin
            start = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
        end
        bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (done) begin
            done_n++;
            done_at = cyc;
        end
        if (bf_valid && bf_ready) begin
            if (q.size() == 0) begin
                n_total++;
                n_bad++;
                $error("FAIL extra_beat observed=%0h expected=none", cur());
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat", 32'(cur()), 32'(e));
            end
            if (beats < 1152) got[beats] = cur();
            beats++;
        end
        snap = cur();
        held = bf_valid && !bf_ready && rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (held) chk("hold", 32'({bf_valid, cur()}), 32'({1'b1, snap}));
    endtask

    task automatic kick(input bit m);
        push_golden(m);
        cyc     = 0;
        beats   = 0;
        done_n  = 0;
        done_at = -1;
        start   = 1'b1;
        mode    = m;
        tick();
        start   = 1'b0;
        chk("busy_valid_c1", 32'({bf_valid, busy}), 32'(2'b11));
    endtask

    task automatic run(input int budget, input int exp_beats, input int exp_done);
        while (done_n == 0 && cyc < budget) tick();
        start = 1'b0;
        chk("done_count", 32'(done_n), 32'(1));
        chk("beat_count", 32'(beats), 32'(exp_beats));
        chk("q_drained", 32'(q.size()), 32'(0));
        if (exp_done > 0) chk("done_cycle", 32'(done_at), 32'(exp_done));
        chk("idle_after_done", 32'({bf_valid, busy, done}), 32'(0));
        q.delete();
    endtask

    initial begin
        cyc = 0; beats = 0; done_n = 0; done_at = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({bf_valid, addr_a, addr_b, tw_addr, layer, scale, busy, done}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // NTT, bf_ready held high
        kick(1'b0);
        run(2000, 896, 897);
        chk("ntt_b0",   32'(got[0]),   32'(mk(0, 128, 1, 0, 0)));
        chk("ntt_b127", 32'(got[127]), 32'(mk(127, 255, 1, 0, 0)));
        chk("ntt_b128", 32'(got[128]), 32'(mk(0, 64, 2, 1, 0)));
        chk("ntt_b192", 32'(got[192]), 32'(mk(128, 192, 3, 1, 0)));
        chk("ntt_b895", 32'(got[895]), 32'(mk(253, 255, 127, 6, 0)));

        // INTT, bf_ready held high
        kick(1'b1);
        run(2000, 1152, 1153);
        chk("intt_b0",   32'(got[0]),   32'(mk(0, 2, 127, 0, 0)));
        chk("intt_b1",   32'(got[1]),   32'(mk(1, 3, 127, 0, 0)));
        chk("intt_b2",   32'(got[2]),   32'(mk(4, 6, 126, 0, 0)));
        chk("intt_b768", 32'(got[768]), 32'(mk(0, 128, 1, 6, 0)));
        chk("intt_b896", 32'(got[896]), 32'(mk(0, 0, 0, 6, 1)));
        chk("intt_b1151", 32'(got[1151]), 32'(mk(255, 255, 0, 6, 1)));

        // random backpressure in both modes
        rnd = 1'b1;
        kick(1'b0);
        run(6000, 896, 0);
        kick(1'b1);
        run(8000, 1152, 0);
        rnd = 1'b0;

        // start/mode noise during RUN, SCALE and DONE, back-to-back with alternating mode
        noise = 1'b1;
        kick(1'b0);
        run(2000, 896, 897);
        kick(1'b1);
        run(2000, 1152, 1153);
        kick(1'b0);
        run(2000, 896, 897);
        noise = 1'b0;
        start = 1'b0;

        // reset at NTT beat 300, then clean restart
        kick(1'b0);
        while (beats < 300 && cyc < 1000) tick();
        chk("beat300_reached", 32'(beats), 32'(300));
        rst_n = 1'b0;
        tick();
        chk("rst_midrun", 32'({bf_valid, addr_a, addr_b, tw_addr, layer, scale, busy, done}), 32'(0));
        rst_n  = 1'b1;
        done_n = 0;
        repeat (5) tick();
        chk("no_done_after_rst", 32'(done_n), 32'(0));
        q.delete();
        kick(1'b0);
        run(2000, 896, 897);
        chk("restart_b0", 32'(got[0]), 32'(mk(0, 128, 1, 0, 0)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
